// File: rtl/exp_pipe_lanes.sv
// Three-stage, multi-lane fixed-point e^x (x <= 0) using a piecewise-linear chord table,
// with per-lane positive-input and underflow saturation flags on a shared valid/ready stream.
module exp_pipe_lanes #(
    parameter int                       DATA_W     = 16,
    parameter int                       FRAC_W     = 12,
    parameter int                       LUT_ADDR_W = 7,
    parameter int                       LANES      = 4,
    parameter logic signed [DATA_W-1:0] UF_LIMIT   = 16'sh9000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_pos_sat,
    output logic [LANES-1:0]        out_uf
);

    localparam int ROM_DEPTH = 1 << LUT_ADDR_W;
    localparam int SEG_SHIFT = DATA_W - 1 - LUT_ADDR_W;
    localparam int HS        = FRAC_W - SEG_SHIFT;
    localparam int QB        = 30;
    localparam int CS        = QB - FRAC_W - HS;
    localparam int PW        = 2 * DATA_W;
    localparam int RW        = DATA_W + 2;
    localparam logic [DATA_W-1:0]        ONE   = DATA_W'(1) << FRAC_W;
    localparam logic signed [RW-1:0]     R_LSB = RW'(1);
    localparam logic signed [RW-1:0]     R_MAX = RW'(ONE);

    // Chord of e^-t over segment seg in QB-bit fixed point: slope truncated, intercept
    // rounded after folding in the truncated slope so each segment start lands on round(e^-a).
    function automatic logic [PW-1:0] chord_coef(input int seg);
        logic [63:0] term, e_step, e_a, e_b, slope, icpt;
        term   = 64'd1 << QB;
        e_step = term;
        for (int k = 1; k <= 10; k++) begin
            term = term / (64'(k) << HS);
            if (k % 2 == 1) e_step = e_step - term;
            else            e_step = e_step + term;
        end
        e_a = 64'd1 << QB;
        for (int k = 0; k < seg; k++) e_a = (e_a * e_step) >> QB;
        e_b   = (e_a * e_step) >> QB;
        slope = (e_a - e_b) >> CS;
        icpt  = (e_a + ((slope * 64'(seg)) << CS) + (64'd1 << (QB - FRAC_W - 1))) >> (QB - FRAC_W);
        return {DATA_W'(slope), DATA_W'(icpt)};
    endfunction

    logic [PW-1:0] rom_tbl [ROM_DEPTH];
    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam logic [PW-1:0] COEF = chord_coef(g);
        assign rom_tbl[g] = COEF;
    end

    logic en;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]       s1_m_q [LANES];
    logic [DATA_W-1:0]       s1_m_d [LANES];
    logic [LANES-1:0]        s1_pos_q, s1_pos_d, s1_uf_q, s1_uf_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_W:0]         s2_prod_q [LANES];
    logic [DATA_W:0]         s2_prod_d [LANES];
    logic [DATA_W-1:0]       s2_icpt_q [LANES];
    logic [DATA_W-1:0]       s2_icpt_d [LANES];
    logic [LANES-1:0]        s2_pos_q, s2_pos_d, s2_uf_q, s2_uf_d;

    logic                    out_valid_q, out_valid_d;
    logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]        out_pos_q, out_pos_d, out_uf_q, out_uf_d;

    logic [PW-1:0]           lane_coef [LANES];
    logic signed [RW-1:0]    lane_r [LANES];

    assign en          = !out_valid_q || out_ready;
    assign in_ready    = en;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_pos_sat = out_pos_q;
    assign out_uf      = out_uf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_m_d     = s1_m_q;
        s1_pos_d   = s1_pos_q;
        s1_uf_d    = s1_uf_q;
        if (en) begin
            s1_valid_d = in_valid;
            for (int k = 0; k < LANES; k++) begin
                s1_m_d[k]   = -in_data[k*DATA_W +: DATA_W];
                s1_pos_d[k] = !in_data[k*DATA_W + DATA_W - 1] && (|in_data[k*DATA_W +: DATA_W]);
                s1_uf_d[k]  = $signed(in_data[k*DATA_W +: DATA_W]) < UF_LIMIT;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_coef[k] = rom_tbl[s1_m_q[k][DATA_W-2 -: LUT_ADDR_W]];
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_icpt_d  = s2_icpt_q;
        s2_pos_d   = s2_pos_q;
        s2_uf_d    = s2_uf_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_pos_d   = s1_pos_q;
            s2_uf_d    = s1_uf_q;
            for (int k = 0; k < LANES; k++) begin
                s2_icpt_d[k] = lane_coef[k][DATA_W-1:0];
                s2_prod_d[k] = (DATA_W+1)'((PW'(s1_m_q[k]) * PW'(lane_coef[k][PW-1 -: DATA_W])) >> FRAC_W);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_r[k] = $signed({2'b00, s2_icpt_q[k]}) - $signed({1'b0, s2_prod_q[k]});
        end
    end

    // Saturation priority: positive input beats underflow beats the clamped chord value.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_pos_d   = out_pos_q;
        out_uf_d    = out_uf_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            out_pos_d   = s2_pos_q;
            out_uf_d    = s2_uf_q;
            for (int k = 0; k < LANES; k++) begin
                if (s2_pos_q[k])            out_data_d[k*DATA_W +: DATA_W] = ONE;
                else if (s2_uf_q[k])        out_data_d[k*DATA_W +: DATA_W] = DATA_W'(1);
                else if (lane_r[k] < R_LSB) out_data_d[k*DATA_W +: DATA_W] = DATA_W'(1);
                else if (lane_r[k] > R_MAX) out_data_d[k*DATA_W +: DATA_W] = ONE;
                else                        out_data_d[k*DATA_W +: DATA_W] = lane_r[k][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s1_pos_q    <= '0;
            s1_uf_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_pos_q    <= '0;
            s2_uf_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pos_q   <= '0;
            out_uf_q    <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_m_q[k]    <= '0;
                s2_prod_q[k] <= '0;
                s2_icpt_q[k] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_m_q      <= s1_m_d;
            s1_pos_q    <= s1_pos_d;
            s1_uf_q     <= s1_uf_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_icpt_q   <= s2_icpt_d;
            s2_pos_q    <= s2_pos_d;
            s2_uf_q     <= s2_uf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pos_q   <= out_pos_d;
            out_uf_q    <= out_uf_d;
        end
    end

endmodule

// File: tb/tb_exp_pipe_lanes.sv
// Directed bench for exp_pipe_lanes: latency, saturation flags, stall/backpressure,
// mid-flight reset and a full lane-0 sweep against a real-valued e^x model.
module tb_exp_pipe_lanes;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_pos_sat;
    logic [3:0]  out_uf;

    int checks   = 0;
    int failures = 0;

    logic [15:0] tx  [16];
    logic [15:0] ty  [16];
    logic        tpos[16];
    logic        tuf [16];

    exp_pipe_lanes dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pos_sat (out_pos_sat),
        .out_uf      (out_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] x);
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic runSingle(input string tag, input logic [63:0] x, input logic [63:0] y,
                             input logic [3:0] pos, input logic [3:0] uf);
        applyStimulus(x);
        checkOutput({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        checkOutput({tag, "_lat2"}, 64'(out_valid), 64'd0);
        step();
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_data"}, out_data, y);
        checkOutput({tag, "_pos"}, 64'(out_pos_sat), 64'(pos));
        checkOutput({tag, "_uf"}, 64'(out_uf), 64'(uf));
        step();
        checkOutput({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    task automatic buildSet(input int n, output logic [63:0] d, output logic [63:0] y,
                            output logic [3:0] p, output logic [3:0] u);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (3 * n + 5 * k) % 16;
            d[k*16 +: 16] = tx[idx];
            y[k*16 +: 16] = ty[idx];
            p[k] = tpos[idx];
            u[k] = tuf[idx];
        end
    endtask

    logic [63:0] set_d, set_y, hold_data;
    logic [3:0]  set_p, set_u;
    logic        stall;
    int          sent, recv;
    logic [15:0] sweep_q[$];
    logic [15:0] sx, so;
    int          xs;
    real         ev, diff;
    logic        ok;

    initial begin
        tx   = '{16'h0000, 16'hF000, 16'hE000, 16'hD000, 16'hC000, 16'hB000, 16'hA000, 16'h9000,
                 16'h8FFF, 16'h8000, 16'h0800, 16'h7FFF, 16'h0001, 16'hFFFF, 16'hEF80, 16'hFF80};
        ty   = '{16'h1000, 16'h05E3, 16'h022A, 16'h00CC, 16'h004B, 16'h001C, 16'h000A, 16'h0004,
                 16'h0001, 16'h0001, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h05B6, 16'h0F84};
        tpos = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        tuf  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", out_data, 64'd0);
        checkOutput("reset_pos", 64'(out_pos_sat), 64'd0);
        checkOutput("reset_uf", 64'(out_uf), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        resetn = 1'b1;
        step();

        $display("[TB] directed single sets");
        runSingle("zero", 64'h0000_0000_0000_0000, 64'h1000_1000_1000_1000, 4'b0000, 4'b0000);
        runSingle("neg1", 64'hF000_F000_F000_F000, 64'h05E3_05E3_05E3_05E3, 4'b0000, 4'b0000);
        runSingle("sat", {16'h9000, 16'h8FFF, 16'h8000, 16'h0800},
                  {16'h0004, 16'h0001, 16'h0001, 16'h1000}, 4'b0001, 4'b0110);
        runSingle("edge", {16'hEF80, 16'h0001, 16'h7FFF, 16'hFFFF},
                  {16'h05B6, 16'h1000, 16'h1000, 16'h1000}, 4'b0110, 4'b0000);
        runSingle("ints", {16'hA000, 16'hB000, 16'hC000, 16'hE000},
                  {16'h000A, 16'h001C, 16'h004B, 16'h022A}, 4'b0000, 4'b0000);

        $display("[TB] stream with backpressure");
        sent = 0;
        recv = 0;
        hold_data = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            stall     = (cyc >= 5 && cyc < 8);
            out_ready = !stall;
            in_valid  = (sent < 8);
            if (sent < 8) begin
                buildSet(sent, set_d, set_y, set_p, set_u);
                in_data = set_d;
            end else begin
                in_data = '0;
            end
            #1;
            checkOutput("stream_in_ready", 64'(in_ready), 64'(!stall));
            if (cyc == 5) hold_data = out_data;
            if (stall) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_stable", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                buildSet(recv, set_d, set_y, set_p, set_u);
                checkOutput("stream_data", out_data, set_y);
                checkOutput("stream_pos", 64'(out_pos_sat), 64'(set_p));
                checkOutput("stream_uf", 64'(out_uf), 64'(set_u));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        checkOutput("stream_count", 64'(recv), 64'd8);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stream_no_dup", 64'(out_valid), 64'd0);
            step();
        end

        $display("[TB] reset with sets in flight");
        for (int n = 0; n < 3; n++) begin
            buildSet(n, set_d, set_y, set_p, set_u);
            in_valid = 1'b1;
            in_data  = set_d;
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("flight_pre_valid", 64'(out_valid), 64'd1);
        resetn = 1'b0;
        #1;
        checkOutput("flight_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("flight_rst_data", out_data, 64'd0);
        step();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("flight_dropped", 64'(out_valid), 64'd0);
            step();
        end

        $display("[TB] lane 0 sweep");
        sent = 0;
        recv = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 65536 + 20 && recv < 65536; cyc++) begin
            if (sent < 65536) begin
                in_valid = 1'b1;
                in_data  = {16'hF000, 16'hF000, 16'hF000, 16'(sent)};
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            #1;
            if (out_valid) begin
                if (sweep_q.size() == 0) begin
                    checkOutput("sweep_spurious", 64'(out_valid), 64'd0);
                end else begin
                    sx = sweep_q.pop_front();
                    so = out_data[15:0];
                    xs = int'($signed(sx));
                    if (xs > 0) begin
                        ok = (so === 16'h1000) && (out_pos_sat[0] === 1'b1) && (out_uf[0] === 1'b0);
                    end else if (xs < -28672) begin
                        ok = (so === 16'h0001) && (out_pos_sat[0] === 1'b0) && (out_uf[0] === 1'b1);
                    end else begin
                        ev   = $exp(real'(xs) / 4096.0) * 4096.0;
                        diff = real'(so) - ev;
                        ok   = (out_pos_sat[0] === 1'b0) && (out_uf[0] === 1'b0) &&
                               (so >= 16'h0001) && (so <= 16'h1000) && (diff <= 4.0) && (diff >= -4.0);
                    end
                    checks++;
                    assert (ok === 1'b1) else begin
                        failures++;
                        $error("[TB] FAIL sweep x=%h observed=%h pos=%b uf=%b required~%0f", sx, so,
                               out_pos_sat[0], out_uf[0], (xs > 0) ? 4096.0 : ((xs < -28672) ? 1.0 : ev));
                    end
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                sweep_q.push_back(16'(sent));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        checkOutput("sweep_count", 64'(recv), 64'd65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
